// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-lane TDM link (transmit serializer and receive demux).
package tdm_pkg;

  localparam int TDM_LANES = 4;
  localparam int TDM_SEL_W = $clog2(TDM_LANES);
  localparam int TDM_CNT_W = 8;

  // Index of the final lane in a frame for the default lane count.
  localparam logic [TDM_SEL_W-1:0] LANE_LAST = TDM_SEL_W'(TDM_LANES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } tdm_state_e;

endpackage

// File: rtl/tdm_demux_4bit_lane_wr_decode.sv
// Lane write-enable decoder: turns a lane index plus a write strobe into a one-hot enable.
module lane_wr_decode #(
  parameter int LANES = 4,
  parameter int SEL_W = $clog2(LANES)
) (
  input  logic [SEL_W-1:0] lane_i,
  input  logic             wr_i,
  output logic [LANES-1:0] wr_en_o
);

  // Demultiplex the strobe onto the selected lane.
  always_comb begin
    // NOTE: the default assignment first guarantees every bit is driven on every path, so no latch.
    wr_en_o = '0;
    if (wr_i) begin
      wr_en_o[lane_i] = 1'b1;
    end
  end

endmodule

// File: rtl/tdm_demux_4bit.sv
// Receive side of the 4-lane TDM link: rebuilds a LANES-bit word from a serial
// beat stream (one bit per lane, lane 0 flagged by s_sof) and presents it on a
// valid/ready output slot, with framing-error pulses and a delivered-word counter.
module tdm_demux_4bit
  import tdm_pkg::*;
#(
  parameter int LANES = TDM_LANES,
  parameter int SEL_W = $clog2(LANES),
  parameter int CNT_W = TDM_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_bit,
  input  logic             s_valid,
  input  logic             s_sof,
  output logic             s_ready,
  output logic [LANES-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             sync_err,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam logic [SEL_W-1:0] LastLane = SEL_W'(LANES - 1);

  tdm_state_e       state_q;
  logic [SEL_W-1:0] lane_q;
  logic [LANES-1:0] asm_q;
  logic [LANES-1:0] asm_d;
  logic [LANES-1:0] m_data_q;
  logic             m_valid_q;
  logic             sync_err_q;
  logic [CNT_W-1:0] frame_cnt_q;

  logic             accept;
  logic             drain;
  logic             wr_stb;
  logic [SEL_W-1:0] wr_sel;
  logic [LANES-1:0] wr_en;

  assign s_ready = (state_q != FULL);
  assign accept  = s_valid && s_ready;
  assign drain   = m_valid_q && m_ready;

  // A SOF beat always lands in lane 0; otherwise the current lane counter selects.
  assign wr_sel = s_sof ? '0 : lane_q;
  assign wr_stb = accept && ((state_q == IDLE && s_sof) || (state_q == COLLECT));

  lane_wr_decode #(
    .LANES (LANES),
    .SEL_W (SEL_W)
  ) u_lane_wr_decode (
    .lane_i  (wr_sel),
    .wr_i    (wr_stb),
    .wr_en_o (wr_en)
  );

  // Next assembly word: enabled lane takes the incoming bit, others keep stale values.
  always_comb begin
    asm_d = asm_q;
    for (int k = 0; k < LANES; k++) begin
      if (wr_en[k]) asm_d[k] = s_bit;
    end
  end

  // Framing FSM, assembly register, output slot and delivered-word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lane_q      <= '0;
      asm_q       <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      sync_err_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      sync_err_q <= 1'b0;
      asm_q      <= asm_d;

      if (drain) begin
        frame_cnt_q <= frame_cnt_q + CNT_W'(1);
        m_valid_q   <= 1'b0;
      end

      // NOTE: later non-blocking assignments in this block win, so a load below overrides the drain clear above.
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (s_sof) begin
              lane_q  <= SEL_W'(1);
              state_q <= COLLECT;
            end else begin
              sync_err_q <= 1'b1;
            end
          end
        end

        COLLECT: begin
          if (accept) begin
            if (s_sof) begin
              sync_err_q <= 1'b1;
              lane_q     <= SEL_W'(1);
            end else if (lane_q == LastLane) begin
              lane_q <= '0;
              if (!m_valid_q || m_ready) begin
                m_data_q  <= asm_d;
                m_valid_q <= 1'b1;
                state_q   <= IDLE;
              end else begin
                state_q <= FULL;
              end
            end else begin
              lane_q <= lane_q + SEL_W'(1);
            end
          end
        end

        FULL: begin
          if (drain) begin
            m_data_q  <= asm_q;
            m_valid_q <= 1'b1;
            state_q   <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign sync_err  = sync_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_tdm_demux_4bit.sv
// Self-checking bench for tdm_demux_4bit: a reference framing model pushes
// completed words to a scoreboard queue, a negedge monitor pops them on handshakes.
module tb_tdm_demux_4bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_bit;
  logic       s_valid;
  logic       s_sof;
  logic       s_ready;
  logic [3:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       sync_err;
  logic [7:0] frame_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard and reference framing model
  logic [3:0] exp_q[$];
  logic [3:0] mdl_bits;
  int         mdl_lane;
  bit         mdl_coll;
  int         exp_sync;
  int         seen_sync;
  int         words_seen;
  logic [7:0] exp_cnt;
  bit         rnd_ready;
  logic [3:0] words[128];

  tdm_demux_4bit dut (
    .clk       (clk),
    .rst       (rst),
    .s_bit     (s_bit),
    .s_valid   (s_valid),
    .s_sof     (s_sof),
    .s_ready   (s_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .sync_err  (sync_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: every handshake pops one expected word and checks the counter.
  always @(negedge clk) begin
    if (!rst) begin
      if (sync_err) seen_sync++;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {28'd0, m_data}, 32'hFFFF_FFFF);
        end else begin
          check("word", {28'd0, m_data}, {28'd0, exp_q.pop_front()});
        end
        check("frame_cnt_pre", {24'd0, frame_cnt}, {24'd0, exp_cnt});
        exp_cnt = exp_cnt + 8'd1;
        words_seen++;
      end
    end
  end

  task automatic model_reset();
    mdl_coll = 1'b0;
    mdl_lane = 0;
    mdl_bits = '0;
    exp_cnt  = '0;
    exp_q.delete();
  endtask

  task automatic model_accept(input logic sof, input logic b);
    if (!mdl_coll) begin
      if (sof) begin
        mdl_bits[0] = b;
        mdl_lane    = 1;
        mdl_coll    = 1'b1;
      end else begin
        exp_sync++;
      end
    end else if (sof) begin
      exp_sync++;
      mdl_bits[0] = b;
      mdl_lane    = 1;
    end else begin
      mdl_bits[mdl_lane] = b;
      if (mdl_lane == 3) begin
        exp_q.push_back(mdl_bits);
        mdl_coll = 1'b0;
        mdl_lane = 0;
      end else begin
        mdl_lane++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
  endtask

  // Drive one beat after `gap` idle cycles; returns just after the accepting edge.
  task automatic beat(input logic sof, input logic b, input int gap);
    int n;
    for (int i = 0; i < gap; i++) begin
      s_valid = 1'b0;
      tick();
    end
    s_valid = 1'b1;
    s_sof   = sof;
    s_bit   = b;
    n = 0;
    while (!s_ready && n < 64) begin
      tick();
      n++;
    end
    if (!s_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      s_valid = 1'b0;
      return;
    end
    model_accept(sof, b);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] w, input int max_gap);
    beat(1'b1, w[0], $urandom_range(0, max_gap));
    for (int i = 1; i < 4; i++) beat(1'b0, w[i], $urandom_range(0, max_gap));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    model_reset();
    rst = 1'b0;
  endtask

  task automatic wait_drained();
    int n = 0;
    m_ready = 1'b1;
    while ((exp_q.size() != 0 || m_valid) && n < 64) begin
      tick();
      n++;
    end
    check("drain_timeout", {31'd0, m_valid}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ws;
    rst = 1'b1; s_bit = 1'b0; s_valid = 1'b0; s_sof = 1'b0; m_ready = 1'b1;
    rnd_ready = 1'b0; exp_sync = 0; seen_sync = 0; words_seen = 0;
    model_reset();
    tick();
    tick();
    model_reset();
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_data", {28'd0, m_data}, 32'd0);
    check("rst_s_ready", {31'd0, s_ready}, 32'd1);
    check("rst_sync_err", {31'd0, sync_err}, 32'd0);
    check("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
    rst = 1'b0;

    // 1: basic frame, 1-cycle latency, single-cycle valid
    beat(1'b1, 1'b1, 0);
    beat(1'b0, 1'b0, 0);
    beat(1'b0, 1'b1, 0);
    beat(1'b0, 1'b1, 0);
    check("t1_valid_after_last", {31'd0, m_valid}, 32'd1);
    check("t1_data", {28'd0, m_data}, 32'hD);
    tick();
    check("t1_valid_one_cycle", {31'd0, m_valid}, 32'd0);
    check("t1_frame_cnt", {24'd0, frame_cnt}, 32'd1);

    // 2: backpressure, FULL hold, back-to-back drain
    m_ready = 1'b0;
    send_word(4'hA, 0);
    send_word(4'h5, 0);
    check("t2_s_ready_full", {31'd0, s_ready}, 32'd0);
    tick();
    tick();
    check("t2_hold_valid", {31'd0, m_valid}, 32'd1);
    check("t2_hold_data", {28'd0, m_data}, 32'hA);
    m_ready = 1'b1;
    tick();
    check("t2_second_valid", {31'd0, m_valid}, 32'd1);
    check("t2_second_data", {28'd0, m_data}, 32'h5);
    check("t2_s_ready_free", {31'd0, s_ready}, 32'd1);
    tick();
    check("t2_drained", {31'd0, m_valid}, 32'd0);

    // 3: early SOF restarts the frame
    ws = words_seen;
    beat(1'b1, 1'b1, 0);
    beat(1'b0, 1'b1, 0);
    beat(1'b1, 1'b0, 0);
    check("t3_sync_err", {31'd0, sync_err}, 32'd1);
    beat(1'b0, 1'b0, 0);
    check("t3_sync_err_pulse", {31'd0, sync_err}, 32'd0);
    beat(1'b0, 1'b1, 0);
    beat(1'b0, 1'b1, 0);
    check("t3_data", {28'd0, m_data}, 32'hC);
    wait_drained();
    check("t3_one_word", words_seen - ws, 32'd1);

    // 4: non-SOF beat while idle is dropped
    ws = words_seen;
    beat(1'b0, 1'b1, 0);
    check("t4_sync_err", {31'd0, sync_err}, 32'd1);
    check("t4_no_valid", {31'd0, m_valid}, 32'd0);
    send_word(4'h6, 0);
    check("t4_data", {28'd0, m_data}, 32'h6);
    wait_drained();
    check("t4_one_word", words_seen - ws, 32'd1);

    // 5: reset mid-frame
    beat(1'b1, 1'b0, 0);
    beat(1'b0, 1'b1, 0);
    do_reset();
    check("t5_m_valid", {31'd0, m_valid}, 32'd0);
    check("t5_m_data", {28'd0, m_data}, 32'd0);
    check("t5_s_ready", {31'd0, s_ready}, 32'd1);
    check("t5_frame_cnt", {24'd0, frame_cnt}, 32'd0);
    send_word(4'h3, 0);
    check("t5_data", {28'd0, m_data}, 32'h3);
    wait_drained();

    // 6: 256 frames, second half with random gaps and backpressure, counter wraps
    do_reset();
    for (int i = 0; i < 128; i++) words[i] = 4'($urandom_range(0, 15));
    for (int i = 0; i < 128; i++) send_word(words[i], 0);
    rnd_ready = 1'b1;
    for (int i = 0; i < 128; i++) send_word(words[i], 2);
    rnd_ready = 1'b0;
    wait_drained();
    check("t6_frame_cnt_wrap", {24'd0, frame_cnt}, 32'd0);
    check("t6_queue_empty", exp_q.size(), 32'd0);

    check("sync_err_total", seen_sync, exp_sync);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
